fft_peak_detect: RTL and testbench

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_peak_detect.sv | 247 ++++++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: scans a 16-bin complex FFT frame and reports the index of
// the bin with the largest squared magnitude (real^2 + imag^2).
// A frame is snapshotted when fft_valid is seen in IDLE. The bins are then
// scanned one per cycle. Ties resolve to the lowest index.
// Optional build macro MAG_PIPE_EN adds a register between the squaring and
// the compare stages. That adds a FLUSH state, and the result lands one cycle
// later.
module fft_peak_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        busy,
  output logic        done,
  output logic [3:0]  freq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
`ifdef MAG_PIPE_EN
    FLUSH = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  // Squared magnitude of one packed bin. The largest case is
  // (-32768)^2 + (-32768)^2 = 2^31, which still fits in 32 unsigned bits.
  function automatic logic [31:0] mag_f(input logic [31:0] bin);
    logic signed [31:0] re_ext;
    logic signed [31:0] im_ext;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    re_ext = {{16{bin[31]}}, bin[31:16]};
    im_ext = {{16{bin[15]}}, bin[15:0]};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        finish_s;

  logic [31:0] fft_in_s [16];
  logic [31:0] bins_r   [16];
  logic [3:0]  idx_r;

  logic [31:0] best_mag_r;
  logic [3:0]  best_idx_r;
  logic [31:0] best_mag_nxt_s;
  logic [3:0]  best_idx_nxt_s;

  logic        cmp_en_s;
  logic [31:0] cmp_mag_s;
  logic [3:0]  cmp_idx_s;
  logic        take_s;

  logic        busy_r;
  logic        done_r;
  logic [3:0]  freq_r;

`ifdef MAG_PIPE_EN
  logic [31:0] mag_r;
  logic [3:0]  mag_idx_r;
  logic        pipe_vld_r;
`endif

  assign fft_in_s[0]  = fft_d0;
  assign fft_in_s[1]  = fft_d1;
  assign fft_in_s[2]  = fft_d2;
  assign fft_in_s[3]  = fft_d3;
  assign fft_in_s[4]  = fft_d4;
  assign fft_in_s[5]  = fft_d5;
  assign fft_in_s[6]  = fft_d6;
  assign fft_in_s[7]  = fft_d7;
  assign fft_in_s[8]  = fft_d8;
  assign fft_in_s[9]  = fft_d9;
  assign fft_in_s[10] = fft_d10;
  assign fft_in_s[11] = fft_d11;
  assign fft_in_s[12] = fft_d12;
  assign fft_in_s[13] = fft_d13;
  assign fft_in_s[14] = fft_d14;
  assign fft_in_s[15] = fft_d15;

  assign busy = busy_r;
  assign done = done_r;
  assign freq = freq_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; finish_s marks the cycle whose edge publishes the result
  always_comb begin
    state_nxt_s = state_r;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fft_valid) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == 4'd15) begin
`ifdef MAG_PIPE_EN
          state_nxt_s = FLUSH;
`else
          state_nxt_s = DONE;
          finish_s    = 1'b1;
`endif
        end else begin
          state_nxt_s = SCAN;
        end
      end
`ifdef MAG_PIPE_EN
      FLUSH: begin
        state_nxt_s = DONE;
        finish_s    = 1'b1;
      end
`endif
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Compare-stage operands: taken straight from the squarer, or from the pipe register
  always_comb begin
`ifdef MAG_PIPE_EN
    cmp_en_s  = pipe_vld_r;
    cmp_mag_s = mag_r;
    cmp_idx_s = mag_idx_r;
`else
    cmp_en_s  = (state_r == SCAN);
    cmp_mag_s = mag_f(bins_r[idx_r]);
    cmp_idx_s = idx_r;
`endif
  end

  // Running maximum: bin 0 always seeds it; later bins replace it only when strictly larger
  always_comb begin
    take_s = 1'b0;
    if (cmp_en_s) begin
      if ((cmp_idx_s == 4'd0) || (cmp_mag_s > best_mag_r)) begin
        take_s = 1'b1;
      end else begin
        take_s = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end
    if (take_s) begin
      best_mag_nxt_s = cmp_mag_s;
      best_idx_nxt_s = cmp_idx_s;
    end else begin
      best_mag_nxt_s = best_mag_r;
      best_idx_nxt_s = best_idx_r;
    end
  end

  // Frame snapshot and scan index; the snapshot is loaded only from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        bins_r[i] <= 32'd0;
      end
      idx_r <= 4'd0;
    end else if ((state_r == IDLE) && fft_valid) begin
      for (int i = 0; i < 16; i++) begin
        bins_r[i] <= fft_in_s[i];
      end
      idx_r <= 4'd0;
    end else if ((state_r == SCAN) && (idx_r != 4'd15)) begin
      idx_r <= idx_r + 4'd1;
    end else begin
      idx_r <= 4'd0;
    end
  end

`ifdef MAG_PIPE_EN
  // Pipeline register between the squarer and the compare stage
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r      <= 32'd0;
      mag_idx_r  <= 4'd0;
      pipe_vld_r <= 1'b0;
    end else begin
      mag_r      <= mag_f(bins_r[idx_r]);
      mag_idx_r  <= idx_r;
      pipe_vld_r <= (state_r == SCAN);
    end
  end
`endif

  // Best-so-far registers
  always_ff @(posedge clk) begin
    if (rst) begin
      best_mag_r <= 32'd0;
      best_idx_r <= 4'd0;
    end else begin
      best_mag_r <= best_mag_nxt_s;
      best_idx_r <= best_idx_nxt_s;
    end
  end

  // Registered outputs: freq loads only on completion; done is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_r <= 4'd0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (finish_s) begin
        freq_r <= best_idx_nxt_s;
      end
      done_r <= finish_s;
      busy_r <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect. The expected peak comes from a
// plain arithmetic argmax over the frame. Expected busy, done and freq come
// from the cycle count since the capture edge.
module tb_fft_peak_detect;

`ifdef MAG_PIPE_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        busy;
  logic        done;
  logic [3:0]  freq;

  int tests_run;
  int tests_failed;
  int model_freq;

  logic [31:0] fa [16];
  logic [31:0] fb [16];

  fft_peak_detect dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .busy(busy), .done(done), .freq(freq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  // Reference: index of the first bin with the largest re^2 + im^2
  function automatic int peak_of(input logic [31:0] f [16]);
    longint best;
    longint m;
    longint re;
    longint im;
    int     bi;
    best = -1;
    bi   = 0;
    for (int k = 0; k < 16; k++) begin
      re = longint'($signed(f[k][31:16]));
      im = longint'($signed(f[k][15:0]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        bi   = k;
      end
    end
    return bi;
  endfunction

  task automatic fill(output logic [31:0] f [16], input int re, input int im);
    for (int k = 0; k < 16; k++) f[k] = mk(re, im);
  endtask

  // Capture frame f at E0 and follow the scan. Optionally present frame f2
  // with fft_valid at edge inj_at, or assert rst at edge rst_at.
  task automatic do_frame(input logic [31:0] f [16], input logic [31:0] f2 [16],
                          input int inj_at, input int rst_at, input string tag);
    int exp_peak;
    exp_peak  = peak_of(f);
    d         = f;
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = $urandom;
    check_val({tag, " busy_e0"}, {31'd0, busy}, 32'd1);
    check_val({tag, " done_e0"}, {31'd0, done}, 32'd0);
    for (int n = 1; n <= LAT + 2; n++) begin
      if (n == inj_at) begin
        d         = f2;
        fft_valid = 1'b1;
      end
      if (n == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      fft_valid = 1'b0;
      if (n == rst_at) begin
        rst        = 1'b0;
        model_freq = 0;
        check_val($sformatf("%s rst_busy", tag), {31'd0, busy}, 32'd0);
        check_val($sformatf("%s rst_done", tag), {31'd0, done}, 32'd0);
        check_val($sformatf("%s rst_freq", tag), {28'd0, freq}, 32'd0);
        return;
      end
      if (n == LAT) model_freq = exp_peak;
      check_val($sformatf("%s busy n%0d", tag, n), {31'd0, busy}, (n <= LAT) ? 32'd1 : 32'd0);
      check_val($sformatf("%s done n%0d", tag, n), {31'd0, done}, (n == LAT) ? 32'd1 : 32'd0);
      check_val($sformatf("%s freq n%0d", tag, n), {28'd0, freq}, model_freq[31:0]);
    end
  endtask

  initial begin
    int re;
    int im;
    tests_run    = 0;
    tests_failed = 0;
    model_freq   = 0;
    rst          = 1'b1;
    fft_valid    = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = 32'd0;
    fill(fb, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset busy", {31'd0, busy}, 32'd0);
    check_val("reset done", {31'd0, done}, 32'd0);
    check_val("reset freq", {28'd0, freq}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single strong bin 5
    fill(fa, 10, 10);
    fa[5] = mk(1000, 0);
    do_frame(fa, fb, -1, -1, "peak5");

    // Tie between bins 3 and 11 resolves to 3
    fill(fa, 0, 0);
    fa[3]  = mk(300, -400);
    fa[11] = mk(300, -400);
    do_frame(fa, fb, -1, -1, "tie3");

    // All-zero frame: freq 0 with a done pulse
    fill(fa, 5, 5);
    do_frame(fa, fb, -1, -1, "pre_zero");
    fill(fa, 0, 0);
    do_frame(fa, fb, -1, -1, "zero");

    // Extreme magnitude 2^31 at bin 15
    fill(fa, 0, 0);
    fa[2]  = mk(32767, 32767);
    fa[15] = mk(-32768, -32768);
    do_frame(fa, fb, -1, -1, "max15");

    // Second frame presented mid-scan is ignored
    fill(fa, 10, 10);
    fa[7] = mk(500, 0);
    fill(fb, 10, 10);
    fb[9] = mk(600, 0);
    do_frame(fa, fb, 5, -1, "ignore9");

    // Reset at E8 aborts, then a fresh frame peaks at 12
    fill(fa, 10, 10);
    fa[4] = mk(900, 0);
    do_frame(fa, fb, -1, 8, "abort");
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("abort idle done n%0d", n), {31'd0, done}, 32'd0);
      check_val($sformatf("abort idle freq n%0d", n), {28'd0, freq}, 32'd0);
    end
    fill(fa, 10, 10);
    fa[12] = mk(-700, 50);
    do_frame(fa, fb, -1, -1, "peak12");

    // rst and fft_valid at the same edge: no capture
    fill(fa, 10, 10);
    d         = fa;
    fft_valid = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    fft_valid  = 1'b0;
    model_freq = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("rstvalid busy n%0d", n), {31'd0, busy}, 32'd0);
      check_val($sformatf("rstvalid done n%0d", n), {31'd0, done}, 32'd0);
      check_val($sformatf("rstvalid freq n%0d", n), {28'd0, freq}, 32'd0);
    end

    // Random frames: full range, and small values that make ties likely
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 16; k++) begin
        if (t % 2 == 0) begin
          fa[k] = $urandom;
        end else begin
          re    = int'($urandom_range(0, 4)) - 2;
          im    = int'($urandom_range(0, 4)) - 2;
          fa[k] = mk(re, im);
        end
      end
      do_frame(fa, fb, -1, -1, $sformatf("rand%0d", t));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
